// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for one shared tri-stated bus.
// Registered one-hot grant, a dead turnaround cycle between owners, boundary-safe preemption.
module bus_arbiter_rr #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             bus_ready,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             bus_busy
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  state_t state, nState;
  logic [ID_W-1:0] ptr, nPtr;
  logic [HW-1:0] hold, nHold;
  logic [N_REQ-1:0] nGrant;
  logic [ID_W-1:0] nId;

  logic [N_REQ-1:0] pickGrant;
  logic [ID_W-1:0] pickId;
  logic pickAny;
  logic ownReq;
  logic others;
  logic preempt;

  // Pick the set bit with the smallest wrapped distance from ptr.
  always_comb begin
    int best;
    int pickK;
    int d;
    best = N_REQ;
    pickK = 0;
    d = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (k >= int'(ptr)) d = k - int'(ptr);
      else d = k + N_REQ - int'(ptr);
      if (req[k] && d < best) begin
        best = d;
        pickK = k;
      end
    end
    pickAny = (best < N_REQ);
    pickId = ID_W'(pickK);
    for (int k = 0; k < N_REQ; k++) begin
      pickGrant[k] = pickAny && (k == pickK);
    end
  end

  assign ownReq = |(req & grant);
  assign others = |(req & ~grant);
  assign preempt = (MAX_HOLD != 0) && (hold >= HMAX)
                   && bus_ready && others;

  always_comb begin
    int o;
    nState = state;
    nGrant = grant;
    nId = grant_id;
    nPtr = ptr;
    nHold = hold;
    o = int'(grant_id) + 1;
    if (o >= N_REQ) o = 0;
    unique case (state)
      IDLE, TURN: begin
        if (pickAny) begin
          nState = OWN;
          nGrant = pickGrant;
          nId = pickId;
          nHold = '0;
        end else begin
          nState = IDLE;
          nGrant = '0;
          nId = '0;
        end
      end
      OWN: begin
        if (hold != HMAX) nHold = hold + 1'b1;
        if (!ownReq || preempt) begin
          nState = TURN;
          nGrant = '0;
          nId = '0;
          nPtr = ID_W'(o);
        end
      end
      default: begin
        nState = IDLE;
        nGrant = '0;
        nId = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      bus_busy <= 1'b0;
      ptr <= '0;
      hold <= '0;
    end else begin
      state <= nState;
      grant <= nGrant;
      grant_id <= nId;
      bus_busy <= |nGrant;
      ptr <= nPtr;
      hold <= nHold;
    end
  end

endmodule
